// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: M0 (data access) and M1 (instruction fetch)
// share one slave bus. The owner keeps the grant for its whole cycle, and an optional watchdog aborts hung transfers.
module wb_arbiter_2m #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RR_MODE        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,

  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,

  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,

  output logic [1:0]              grant_o
);

  localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam bit          RR_EN         = (RR_MODE != 0);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TOUT} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;     // master granted most recently: 0 = M0, 1 = M1
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  err_q, err_d;       // one-hot owner of the aborted cycle while in TOUT

  logic own_cyc, own_stb;

  assign own_cyc = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (state_q == GNT1) ? m1_stb_i : m0_stb_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = (RR_EN && !last_q) ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
          cnt_d   = '0;
        end else if (TIMEOUT_EN && own_stb && !s_ack_i && (cnt_q + 16'd1 == TIMEOUT_LIMIT)) begin
          state_d = TOUT;
          err_d   = (state_q == GNT1) ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end else if (!TIMEOUT_EN || !own_stb || s_ack_i) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TOUT: begin
        state_d = IDLE;
        last_d  = err_q[1];
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Bus mux is combinational off the registered state so acks add no latency.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
  assign grant_o  = grant_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: instance A is fixed priority with a 4-cycle timeout,
// instance B is round-robin with no timeout; both share the same master/slave stimulus.
module tb_wb_arbiter_2m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
  logic [3:0]  a_s_sel;
  logic [1:0]  a_grant;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic [3:0]  b_s_sel;
  logic [1:0]  b_grant;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_dat_o(a_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_dat_o(a_m1_dat),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(a_grant)
  );

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_dat_o(b_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_dat_o(b_m1_dat),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(b_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
    s_ack = 0; s_dat = 32'h0000_0055;
    #2 reset_n = 0;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL reset_s_cyc got=%b exp=0", a_s_cyc); end
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got=%b exp=00", a_grant); end
    n_cmp++; if (a_m0_dat !== 32'h55) begin n_err++; $display("FAIL reset_m0_dat got=%h exp=00000055", a_m0_dat); end
    n_cmp++; if (b_m1_dat !== 32'h55) begin n_err++; $display("FAIL reset_m1_dat got=%h exp=00000055", b_m1_dat); end
    m0_cyc = 1; m0_stb = 1;
    tick(); tick();
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL reset_hold_grant got=%b exp=00", a_grant); end
    n_cmp++; if (a_s_stb !== 1'b0) begin n_err++; $display("FAIL reset_hold_stb got=%b exp=0", a_s_stb); end
    m0_cyc = 0; m0_stb = 0;
    reset_n = 1;
    tick();
  endtask

  task automatic test_single_read();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h8000_0000; m1_sel = 4'hF;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL single_req_s_cyc got=%b exp=0", a_s_cyc); end
    tick();
    n_cmp++; if (a_s_cyc !== 1'b1) begin n_err++; $display("FAIL single_gnt_s_cyc got=%b exp=1", a_s_cyc); end
    n_cmp++; if (a_s_adr !== 32'h8000_0000) begin n_err++; $display("FAIL single_adr got=%h exp=80000000", a_s_adr); end
    n_cmp++; if (a_s_sel !== 4'hF) begin n_err++; $display("FAIL single_sel got=%h exp=f", a_s_sel); end
    n_cmp++; if (a_grant !== 2'b10) begin n_err++; $display("FAIL single_grant got=%b exp=10", a_grant); end
    tick();
    n_cmp++; if (a_m1_ack !== 1'b0) begin n_err++; $display("FAIL single_wait_ack got=%b exp=0", a_m1_ack); end
    tick();
    s_ack = 1; s_dat = 32'h0000_0013;
    #1;
    n_cmp++; if (a_m1_ack !== 1'b1) begin n_err++; $display("FAIL single_ack got=%b exp=1", a_m1_ack); end
    n_cmp++; if (a_m1_dat !== 32'h13) begin n_err++; $display("FAIL single_dat got=%h exp=00000013", a_m1_dat); end
    n_cmp++; if (a_m0_ack !== 1'b0) begin n_err++; $display("FAIL single_other_ack got=%b exp=0", a_m0_ack); end
    n_cmp++; if (b_m1_ack !== 1'b1) begin n_err++; $display("FAIL single_b_ack got=%b exp=1", b_m1_ack); end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL single_drop_s_cyc got=%b exp=0", a_s_cyc); end
    n_cmp++; if (a_grant !== 2'b10) begin n_err++; $display("FAIL single_drop_grant got=%b exp=10", a_grant); end
    tick();
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL single_after_grant got=%b exp=00", a_grant); end
  endtask

  task automatic test_fixed_priority();
    idle_all();
    m0_adr = 32'h100; m1_adr = 32'h200;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL fixed_grant%0d got=%b exp=01", rep, a_grant); end
      n_cmp++; if (a_s_adr !== 32'h100) begin n_err++; $display("FAIL fixed_adr%0d got=%h exp=00000100", rep, a_s_adr); end
      s_ack = 1;
      #1;
      n_cmp++; if (a_m0_ack !== 1'b1) begin n_err++; $display("FAIL fixed_m0_ack%0d got=%b exp=1", rep, a_m0_ack); end
      n_cmp++; if (a_m1_ack !== 1'b0) begin n_err++; $display("FAIL fixed_m1_ack%0d got=%b exp=0", rep, a_m1_ack); end
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      if (rep == 0) begin m0_cyc = 1; m0_stb = 1; end
      #1;
      n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL fixed_idle%0d got=%b exp=00", rep, a_grant); end
    end
    tick();
    n_cmp++; if (a_grant !== 2'b10) begin n_err++; $display("FAIL fixed_m1_grant got=%b exp=10", a_grant); end
    n_cmp++; if (a_s_adr !== 32'h200) begin n_err++; $display("FAIL fixed_m1_adr got=%h exp=00000200", a_s_adr); end
    s_ack = 1;
    #1;
    n_cmp++; if (a_m1_ack !== 1'b1) begin n_err++; $display("FAIL fixed_m1_ack_end got=%b exp=1", a_m1_ack); end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_adr = 32'h100; m1_adr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      logic exp_m1;
      exp_m1 = (i % 2) == 1;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      #1;
      n_cmp++; if (b_grant !== 2'b00) begin n_err++; $display("FAIL rr_idle%0d got=%b exp=00", i, b_grant); end
      tick();
      n_cmp++; if (b_grant !== (exp_m1 ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", i, b_grant, exp_m1 ? 2'b10 : 2'b01); end
      n_cmp++; if (b_s_adr !== (exp_m1 ? 32'h200 : 32'h100)) begin n_err++; $display("FAIL rr_adr%0d got=%h", i, b_s_adr); end
      s_ack = 1;
      #1;
      n_cmp++; if (b_m1_ack !== exp_m1) begin n_err++; $display("FAIL rr_m1_ack%0d got=%b exp=%b", i, b_m1_ack, exp_m1); end
      n_cmp++; if (b_m0_ack !== !exp_m1) begin n_err++; $display("FAIL rr_m0_ack%0d got=%b exp=%b", i, b_m0_ack, !exp_m1); end
      tick();
      s_ack = 0;
      if (exp_m1) begin m1_cyc = 0; m1_stb = 0; end
      else begin m0_cyc = 0; m0_stb = 0; end
      #1;
      n_cmp++; if (b_s_cyc !== 1'b0) begin n_err++; $display("FAIL rr_release%0d got=%b exp=0", i, b_s_cyc); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_burst();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h40; m0_dat = 32'hA5A5_0000; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    tick();
    for (int beat = 0; beat < 3; beat++) begin
      m0_adr = 32'h40 + 32'(beat * 4);
      m0_dat = 32'hA5A5_0000 + 32'(beat);
      s_ack = 1;
      #1;
      n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL burst_grant%0d got=%b exp=01", beat, a_grant); end
      n_cmp++; if (a_m0_ack !== 1'b1) begin n_err++; $display("FAIL burst_m0_ack%0d got=%b exp=1", beat, a_m0_ack); end
      n_cmp++; if (a_m1_ack !== 1'b0) begin n_err++; $display("FAIL burst_m1_ack%0d got=%b exp=0", beat, a_m1_ack); end
      n_cmp++; if (a_s_dat !== 32'hA5A5_0000 + 32'(beat)) begin n_err++; $display("FAIL burst_dat%0d got=%h", beat, a_s_dat); end
      n_cmp++; if (a_s_adr !== 32'h40 + 32'(beat * 4)) begin n_err++; $display("FAIL burst_adr%0d got=%h", beat, a_s_adr); end
      tick();
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL burst_drop_grant got=%b exp=01", a_grant); end
    tick();
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL burst_idle_grant got=%b exp=00", a_grant); end
    n_cmp++; if (a_m1_ack !== 1'b0) begin n_err++; $display("FAIL burst_idle_m1_ack got=%b exp=0", a_m1_ack); end
    tick();
    n_cmp++; if (a_grant !== 2'b10) begin n_err++; $display("FAIL burst_m1_grant got=%b exp=10", a_grant); end
    s_ack = 1;
    #1;
    n_cmp++; if (a_m1_ack !== 1'b1) begin n_err++; $display("FAIL burst_m1_ack_end got=%b exp=1", a_m1_ack); end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
  endtask

  task automatic test_timeout();
    idle_all();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    #1;
    n_cmp++; if (a_grant !== 2'b10) begin n_err++; $display("FAIL tout_grant got=%b exp=10", a_grant); end
    n_cmp++; if (a_m1_err !== 1'b0) begin n_err++; $display("FAIL tout_err_g0 got=%b exp=0", a_m1_err); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++; if (a_m1_err !== 1'b0) begin n_err++; $display("FAIL tout_err_g%0d got=%b exp=0", k, a_m1_err); end
      n_cmp++; if (a_s_cyc !== 1'b1) begin n_err++; $display("FAIL tout_cyc_g%0d got=%b exp=1", k, a_s_cyc); end
    end
    tick();
    s_ack = 1;
    #1;
    n_cmp++; if (a_m1_err !== 1'b1) begin n_err++; $display("FAIL tout_err_pulse got=%b exp=1", a_m1_err); end
    n_cmp++; if (a_m0_err !== 1'b0) begin n_err++; $display("FAIL tout_m0_err got=%b exp=0", a_m0_err); end
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL tout_s_cyc got=%b exp=0", a_s_cyc); end
    n_cmp++; if (a_s_stb !== 1'b0) begin n_err++; $display("FAIL tout_s_stb got=%b exp=0", a_s_stb); end
    n_cmp++; if (a_m1_ack !== 1'b0) begin n_err++; $display("FAIL tout_ack_dropped got=%b exp=0", a_m1_ack); end
    n_cmp++; if (b_m1_err !== 1'b0) begin n_err++; $display("FAIL tout_disabled_err got=%b exp=0", b_m1_err); end
    n_cmp++; if (b_s_cyc !== 1'b1) begin n_err++; $display("FAIL tout_disabled_cyc got=%b exp=1", b_s_cyc); end
    n_cmp++; if (b_m1_ack !== 1'b1) begin n_err++; $display("FAIL tout_disabled_ack got=%b exp=1", b_m1_ack); end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    n_cmp++; if (a_m1_err !== 1'b0) begin n_err++; $display("FAIL tout_err_end got=%b exp=0", a_m1_err); end
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL tout_idle_grant got=%b exp=00", a_grant); end
    tick();
    n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL tout_m0_grant got=%b exp=01", a_grant); end
    n_cmp++; if (a_s_adr !== 32'h100) begin n_err++; $display("FAIL tout_m0_adr got=%h exp=00000100", a_s_adr); end
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
  endtask

  task automatic test_async_reset();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h500; m0_sel = 4'hF;
    tick();
    n_cmp++; if (a_s_cyc !== 1'b1) begin n_err++; $display("FAIL areset_pre_cyc got=%b exp=1", a_s_cyc); end
    n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL areset_pre_grant got=%b exp=01", a_grant); end
    #2;
    reset_n = 0; s_ack = 1; s_dat = 32'h0000_0077;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL areset_cyc got=%b exp=0", a_s_cyc); end
    n_cmp++; if (a_s_stb !== 1'b0) begin n_err++; $display("FAIL areset_stb got=%b exp=0", a_s_stb); end
    n_cmp++; if (a_s_we !== 1'b0) begin n_err++; $display("FAIL areset_we got=%b exp=0", a_s_we); end
    n_cmp++; if (a_s_adr !== 32'h0) begin n_err++; $display("FAIL areset_adr got=%h exp=00000000", a_s_adr); end
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL areset_grant got=%b exp=00", a_grant); end
    n_cmp++; if (a_m0_ack !== 1'b0) begin n_err++; $display("FAIL areset_ack got=%b exp=0", a_m0_ack); end
    n_cmp++; if (a_m0_dat !== 32'h77) begin n_err++; $display("FAIL areset_dat got=%h exp=00000077", a_m0_dat); end
    m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
    tick();
    reset_n = 1;
    tick();
    n_cmp++; if (a_grant !== 2'b00) begin n_err++; $display("FAIL areset_post_grant got=%b exp=00", a_grant); end
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++; $display("FAIL areset_post_cyc got=%b exp=0", a_s_cyc); end
    m0_cyc = 1; m0_stb = 1;
    tick();
    n_cmp++; if (a_grant !== 2'b01) begin n_err++; $display("FAIL areset_regrant got=%b exp=01", a_grant); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_round_robin();
    test_burst();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone arbiter sharing the single memory bus between the data-access master (M0, memory stage) and the instruction-fetch master (M1). Sits between the pipeline's bus masters and the memory/peripheral interconnect. Holds the grant for a master's whole bus cycle, supports fixed or round-robin priority, and optionally terminates hung transfers with a per-master error pulse.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8
- RR_MODE, 0, 0 = fixed priority (M0 wins), 1 = round-robin
- TIMEOUT_CYCLES, 0, max cycles waiting for ack; 0 disables timeout; 1..65535 legal

- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- mX_cyc_i, mX_stb_i, mX_we_i  in  1 each  master X (X = 0, 1) cycle/strobe/write
- mX_adr_i  in  ADDR_WIDTH  master X address
- mX_dat_i  in  DATA_WIDTH  master X write data
- mX_sel_i  in  DATA_WIDTH/8  master X byte selects
- mX_ack_o  out  1  ack to master X
- mX_err_o  out  1  timeout error pulse to master X
- mX_dat_o  out  DATA_WIDTH  read data to master X
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH; s_sel_o  out  DATA_WIDTH/8
- s_ack_i  in  1; s_dat_i  in  DATA_WIDTH  from slave
- grant_o  out  2  one-hot current owner (bit0 = M0, bit1 = M1), 00 when idle

## Operation
- States: IDLE, GNT0, GNT1, TOUT.
- IDLE: all s_* control outputs 0. Arbitration on mX_cyc_i:
  - only one requests -> GNTx next cycle.
  - both request, RR_MODE=0 -> GNT0.
  - both request, RR_MODE=1 -> grant the master not granted last; `last` register resets to M1, so M0 wins first contention.
- GNTx: s_cyc/stb/we/adr/dat/sel combinationally follow master X. s_ack_i routes only to mX_ack_o; other master's ack/err stay 0. s_dat_i fans out to both mX_dat_o unconditionally.
- Grant is locked while mX_cyc_i=1, across any number of stb/ack beats. mX_cyc_i=0 in GNTx -> IDLE next cycle, `last` <= X. Minimum one IDLE cycle between grants.
- Timeout, only when TIMEOUT_CYCLES > 0:
  - 16-bit counter clears on entering GNTx, on any s_ack_i, and whenever mX_stb_i=0.
  - Counter increments each GNTx cycle with stb=1 and no ack.
  - Counter reaching TIMEOUT_CYCLES -> TOUT.
- TOUT: one cycle. mX_err_o=1 to the owning master; s_cyc_o=s_stb_o=0, aborting the slave cycle. Next state IDLE, `last` <= X. An s_ack_i arriving in TOUT is dropped, not forwarded.
- A master dropping cyc mid-wait is legal: slave sees cyc fall the same cycle, arbiter goes to IDLE.

## Timing
- Reset (reset_n=0, async): state IDLE, counter 0, `last`=M1. All s_* outputs, mX_ack_o, mX_err_o and grant_o are 0 immediately. mX_dat_o follows s_dat_i.
- Reset mid-transfer: slave cycle is aborted at once and no ack is delivered.
- Grant latency: request at edge N -> s_cyc_o high after edge N+1, one cycle.
- Ack path is combinational, zero added latency.
- Zero-wait slave beat: master sees ack in the same cycle stb reaches the slave.
- Timeout: s_stb_o high at GNT entry cycle G with no ack -> err in cycle G+TIMEOUT_CYCLES.
- grant_o is registered and equals the state decode.

## Test plan
- Reset, then M1 alone reads 0x8000_0000, slave acks 2 cycles later with 0x0000_0013 -> s_cyc_o high 1 cycle after request; m1_ack_o with m1_dat_o=0x13; grant_o=10 during cycle, 00 after.
- RR_MODE=0, M0 and M1 request in the same cycle, each for repeated cycles -> M0 always granted; M1 waits until M0 drops cyc.
- RR_MODE=1, both request continuously, each cycle 1 beat -> grants alternate M0, M1, M0, M1, with one IDLE cycle between each.
- M0 holds cyc for a 3-beat burst while M1 requests -> grant stays 01 for all 3 acks; M1 granted only after M0 cyc falls plus one IDLE cycle; m1_ack_o stays 0 throughout.
- TIMEOUT_CYCLES=4, slave never acks M1 -> m1_err_o pulses exactly 4 cycles after GNT1 entry; s_cyc_o drops that cycle; a pending M0 is granted afterwards.
- Assert reset_n low while GNT0 with stb high -> all s_* outputs and grant_o go 0 without waiting for a clk edge; after release, state is IDLE.
